cache_arbiter: RTL and testbench

Shares the single burst physical-memory port between the instruction cache and the data cache in the mp4 core. Each cache issues whole-line read (and, for data, write-back) requests. The arbiter grants one requester at a time, serialises the line into fixed-width pmem beats, and returns a one-cycle response to the granted cache. It sits between the two cache miss paths and the pmem interface of the top level.

---
 rtl/cache_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cache_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Shares one burst pmem port between I$ and D$: line -> BEATS pmem beats, one-cycle resp to the granted cache.
// Latency: 1 grant + BEATS beats (+pmem waits) + 1 DONE cycle; requests are held by the caches until resp, pmem stalls via pmem_resp.
`timescale 1ns/1ps
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [BEAT_W-1:0] pmem_rdata
);

  localparam int BEATS   = LINE_W / BEAT_W;
  localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W   = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [BEAT_CW-1:0]  beat;
  logic                last_d;   // most recent completed grant went to the data cache
  logic                grant_d;  // current/just-finished burst belongs to the data cache
  logic [31:0]         addr_q;
  logic [LINE_W-1:0]   line_q;   // write-back source, or read line under assembly
  logic [LINE_W-1:0]   line_fill;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic last_beat;
  logic burst_last;

  assign i_req      = i_read;
  assign d_req      = d_read | d_write;
  // On contention the data cache wins unless it was the last one served.
  assign pick_d     = d_req & (~i_req | ~last_d);
  assign last_beat  = (beat == BEAT_CW'(BEATS - 1));
  assign burst_last = pmem_resp & last_beat;

  always_comb begin
    line_fill = line_q;
    line_fill[beat*BEAT_W +: BEAT_W] = pmem_rdata;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nxt = d_write ? D_WRITE : D_READ;
        end else if (i_req) begin
          state_nxt = I_READ;
        end
      end
      I_READ, D_READ, D_WRITE: begin
        if (burst_last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_wdata = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      I_READ, D_READ: pmem_read = 1'b1;
      D_WRITE: begin
        pmem_write = 1'b1;
        pmem_wdata = line_q[beat*BEAT_W +: BEAT_W];
      end
      DONE: begin
        i_resp = ~grant_d;
        d_resp = grant_d;
      end
      default: ;
    endcase
  end

  assign pmem_address = addr_q;

  // Datapath: grant capture, beat counting, line assembly and delivery
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat    <= '0;
      last_d  <= 1'b0;
      grant_d <= 1'b0;
      addr_q  <= '0;
      line_q  <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (pick_d) begin
            grant_d <= 1'b1;
            addr_q  <= {d_addr[31:OFF_W], {OFF_W{1'b0}}};
            if (d_write) begin
              line_q <= d_wdata;
            end
          end else if (i_req) begin
            grant_d <= 1'b0;
            addr_q  <= {i_addr[31:OFF_W], {OFF_W{1'b0}}};
          end
        end
        I_READ, D_READ: begin
          if (pmem_resp) begin
            line_q <= line_fill;
            beat   <= last_beat ? '0 : beat + BEAT_CW'(1);
            if (last_beat) begin
              if (state == I_READ) begin
                i_rdata <= line_fill;
              end else begin
                d_rdata <= line_fill;
              end
            end
          end
        end
        D_WRITE: begin
          if (pmem_resp) begin
            beat <= last_beat ? '0 : beat + BEAT_CW'(1);
          end
        end
        DONE:    last_d <= grant_d;
        default: ;
      endcase
    end
  end

  // Structural invariants of the port protocol
  a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(pmem_read && pmem_write));
  a_resp_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(i_resp && d_resp));
  a_resp_single: assert property (@(posedge clk) disable iff (!rst)
    (i_resp || d_resp) |=> !(i_resp || d_resp));
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
    ((pmem_read || pmem_write) && !burst_last) |=> $stable(pmem_address));

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: bench-side memory model answers pmem, drivers push expected lines,
// a negedge monitor checks grants, beats, addresses and returned lines against the queued expectations.
`timescale 1ns/1ps
module tb_cache_arbiter;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, i_resp;
  logic [31:0]       i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read, d_write, d_resp;
  logic [31:0]       d_addr;
  logic [LINE_W-1:0] d_wdata, d_rdata;
  logic              pmem_read, pmem_write, pmem_resp;
  logic [31:0]       pmem_address;
  logic [BEAT_W-1:0] pmem_wdata, pmem_rdata;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  typedef struct {
    logic [31:0]       addr;
    logic              wr;
    logic [LINE_W-1:0] line;
  } exp_t;

  exp_t              i_q[$];
  exp_t              d_q[$];
  logic [LINE_W-1:0] ref_mem [logic [31:0]];
  logic [LINE_W-1:0] pmem_mem[logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pmem_wait = 0;
  bit rand_wait = 0;
  bit stray_en = 0;
  int i_resp_cnt = 0, d_resp_cnt = 0, rd_cycles = 0, wr_cycles = 0;
  int mon_beat = 0;
  int grant_log[$];
  logic [31:0] last_burst_addr = '0;

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  function automatic logic [LINE_W-1:0] default_line(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    for (int b = 0; b < BEATS; b++)
      l[b*BEAT_W +: BEAT_W] = {la ^ 32'h5a5a_0000, la + 32'(b) * 32'h0101_0101};
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] ref_line(input logic [31:0] la);
    return ref_mem.exists(la) ? ref_mem[la] : default_line(la);
  endfunction

  function automatic logic [LINE_W-1:0] pmem_line(input logic [31:0] la);
    return pmem_mem.exists(la) ? pmem_mem[la] : default_line(la);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic chk(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // pmem model: fixed or random wait states, stray resp pulses outside bursts
  initial begin
    int wcnt, bcnt;
    bit fire;
    logic [LINE_W-1:0] l;
    wcnt = 0; bcnt = 0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst && (pmem_read || pmem_write)) begin
        fire = rand_wait ? ($urandom_range(0, 2) == 0) : (wcnt >= pmem_wait);
        if (fire) begin
          pmem_resp = 1'b1;
          wcnt = 0;
          l = pmem_line(pmem_address);
          if (pmem_read) begin
            pmem_rdata = l[(bcnt & 3)*BEAT_W +: BEAT_W];
          end else begin
            l[(bcnt & 3)*BEAT_W +: BEAT_W] = pmem_wdata;
            pmem_mem[pmem_address] = l;
            pmem_rdata = {$urandom, $urandom};
          end
          bcnt++;
        end else begin
          pmem_resp = 1'b0;
          pmem_rdata = {$urandom, $urandom};
          wcnt++;
        end
      end else begin
        wcnt = 0; bcnt = 0;
        pmem_resp = rst && stray_en && ($urandom_range(0, 1) == 1);
        pmem_rdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit in_burst, b_d, b_wr, burst_end, exp_d, exp_i, prev_i, prev_d, last_d;
    logic [31:0] b_addr;
    logic [LINE_W-1:0] b_line, last_i_exp, last_d_exp;
    exp_t e;
    in_burst = 0; b_d = 0; b_wr = 0; prev_i = 0; prev_d = 0; last_d = 0;
    b_addr = '0; b_line = '0; last_i_exp = '0; last_d_exp = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_burst = 0; last_d = 0; prev_i = 0; prev_d = 0; mon_beat = 0;
        last_i_exp = '0; last_d_exp = '0;
      end else begin
        burst_end = 0;
        if (pmem_read) rd_cycles++;
        if (pmem_write) wr_cycles++;
        if (pmem_read || pmem_write) chk("rw_exclusive", pmem_read & pmem_write, 0);
        if (!in_burst && (pmem_read || pmem_write)) begin
          exp_d = prev_d && (!prev_i || !last_d);
          exp_i = prev_i && !exp_d;
          chk("grant_has_requester", exp_d | exp_i, 1);
          chk("grant_has_expect", exp_d ? (d_q.size() > 0) : (i_q.size() > 0), 1);
          b_d = exp_d;
          if (exp_d && d_q.size() > 0) begin
            b_addr = line_of(d_q[0].addr); b_wr = d_q[0].wr; b_line = d_q[0].line;
          end else if (i_q.size() > 0) begin
            b_addr = line_of(i_q[0].addr); b_wr = 0; b_line = i_q[0].line;
          end
          chk("burst_is_write", pmem_write, b_wr);
          chk("burst_addr", pmem_address, b_addr);
          grant_log.push_back(int'(b_d));
          last_d = b_d;
          last_burst_addr = pmem_address;
          in_burst = 1;
          mon_beat = 0;
        end else if (in_burst && (pmem_read || pmem_write)) begin
          chk("addr_stable", pmem_address, b_addr);
        end else if (in_burst) begin
          burst_end = 1;
          in_burst = 0;
          chk("beats_per_burst", mon_beat, BEATS);
        end
        if (in_burst && pmem_write)
          chk("wdata_beat", pmem_wdata, b_line[(mon_beat & 3)*BEAT_W +: BEAT_W]);
        if (in_burst && pmem_resp) mon_beat++;
        if (burst_end || i_resp || d_resp) begin
          chk("i_resp", i_resp, burst_end && !b_d);
          chk("d_resp", d_resp, burst_end && b_d);
        end
        if (i_resp) begin
          i_resp_cnt++;
          chk("i_resp_has_expect", i_q.size() > 0, 1);
          chk("d_rdata_held", d_rdata, last_d_exp);
          if (i_q.size() > 0) begin
            e = i_q.pop_front();
            chk("i_rdata", i_rdata, e.line);
            last_i_exp = e.line;
          end
        end
        if (d_resp) begin
          d_resp_cnt++;
          chk("d_resp_has_expect", d_q.size() > 0, 1);
          chk("i_rdata_held", i_rdata, last_i_exp);
          if (d_q.size() > 0) begin
            e = d_q.pop_front();
            if (!e.wr) begin
              chk("d_rdata", d_rdata, e.line);
              last_d_exp = e.line;
            end
          end
        end
        prev_i = i_read;
        prev_d = d_read | d_write;
      end
    end
  end

  task automatic do_i(input logic [31:0] a, output int lat);
    exp_t e;
    int t0;
    bit got;
    @(posedge clk); #1;
    i_read = 1'b1; i_addr = a;
    e.addr = a; e.wr = 1'b0; e.line = ref_line(line_of(a));
    i_q.push_back(e);
    t0 = cyc; got = 0; lat = -1;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (i_resp) begin got = 1; lat = cyc - t0 + 1; end
    end
    chk("i_resp_seen", got, 1);
    @(posedge clk); #1;
    i_read = 1'b0; i_addr = $urandom;
  endtask

  task automatic do_d(input logic [31:0] a, input logic rd, input logic wr, input logic [LINE_W-1:0] wd);
    exp_t e;
    bit got;
    @(posedge clk); #1;
    d_read = rd; d_write = wr; d_addr = a; d_wdata = wd;
    e.addr = a; e.wr = wr;
    if (wr) begin
      e.line = wd;
      ref_mem[line_of(a)] = wd;
    end else begin
      e.line = ref_line(line_of(a));
    end
    d_q.push_back(e);
    got = 0;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (d_resp) got = 1;
    end
    chk("d_resp_seen", got, 1);
    @(posedge clk); #1;
    d_read = 1'b0; d_write = 1'b0; d_addr = $urandom; d_wdata = rand_line();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] l, wl;
    int lat, lat2, c0, r0, w0;
    exp_t e;
    rst = 1'b1;
    i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Lone instruction read, zero-wait pmem
    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    ref_mem[32'h60] = l; pmem_mem[32'h60] = l;
    pmem_wait = 0;
    do_i(32'h0000_0064, lat);
    chk("i_latency", lat, 6);
    chk("i_rdata_directed", i_rdata, l);
    chk("i_addr_masked", last_burst_addr, 32'h0000_0060);

    // Lone write-back with two wait cycles per beat, then read it back
    wl = rand_line();
    pmem_wait = 2;
    c0 = d_resp_cnt;
    do_d(32'h0001_0100, 1'b0, 1'b1, wl);
    chk("d_resp_once", d_resp_cnt - c0, 1);
    pmem_wait = 1;
    do_d(32'h0001_0108, 1'b1, 1'b0, '0);
    chk("d_readback", d_rdata, wl);

    // d_read and d_write together: write wins
    wl = rand_line();
    pmem_wait = 0;
    r0 = rd_cycles; w0 = wr_cycles;
    do_d(32'h0001_0140, 1'b1, 1'b1, wl);
    chk("rw_both_no_read", rd_cycles - r0, 0);
    chk("rw_both_write_beats", wr_cycles - w0, BEATS);
    chk("rw_both_mem", pmem_line(32'h0001_0140), wl);

    // Stray pmem_resp in IDLE and DONE
    stray_en = 1;
    c0 = i_resp_cnt + d_resp_cnt; r0 = rd_cycles; w0 = wr_cycles;
    repeat (20) @(posedge clk);
    chk("stray_no_resp", i_resp_cnt + d_resp_cnt - c0, 0);
    chk("stray_no_burst", (rd_cycles - r0) + (wr_cycles - w0), 0);
    do_i(32'h0000_0200, lat);
    do_d(32'h0001_0100, 1'b1, 1'b0, '0);
    stray_en = 0;

    // Simultaneous pairs straight after reset: data first both times
    @(posedge clk); #3 rst = 1'b0;
    grant_log.delete();
    @(posedge clk); #3 rst = 1'b1;
    fork
      do_i(32'h0000_0300, lat);
      do_d(32'h0001_0180, 1'b1, 1'b0, '0);
    join
    fork
      do_i(32'h0000_0320, lat2);
      do_d(32'h0001_01a0, 1'b1, 1'b0, '0);
    join
    chk("pair_grant_count", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      chk("pair1_first", grant_log[0], 1);
      chk("pair1_second", grant_log[1], 0);
      chk("pair2_first", grant_log[2], 1);
      chk("pair2_second", grant_log[3], 0);
    end

    // Reset in the middle of a write-back after two beats
    pmem_wait = 1;
    wl = rand_line();
    @(posedge clk); #1;
    d_write = 1'b1; d_addr = 32'h0002_0000; d_wdata = wl;
    e.addr = 32'h0002_0000; e.wr = 1'b1; e.line = wl;
    d_q.push_back(e);
    for (int n = 0; n < 200 && mon_beat < 2; n++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #2;
    chk("pre_reset_in_write", pmem_write, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_pmem_write", pmem_write, 0);
    chk("mid_rst_d_resp", d_resp, 0);
    chk("mid_rst_pmem_wdata", pmem_wdata, 0);
    chk("mid_rst_pmem_address", pmem_address, 0);
    chk("mid_rst_d_rdata", d_rdata, 0);
    d_write = 1'b0;
    i_q.delete(); d_q.delete();
    @(posedge clk);
    @(posedge clk); #3 rst = 1'b1;
    pmem_wait = 0;
    do_i(32'h0000_1040, lat);
    chk("post_reset_addr", last_burst_addr, 32'h0000_1040);

    // Randomised concurrent traffic
    rand_wait = 1; stray_en = 1;
    fork
      begin
        int li;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          do_i(32'($urandom_range(0, 32'h7fff)), li);
        end
      end
      begin
        int op;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          op = $urandom_range(0, 4);
          do_d(32'h0001_0000 + 32'($urandom_range(0, 32'h1ff)),
               (op < 2) || (op == 4), (op >= 2), rand_line());
        end
      end
    join
    rand_wait = 0; stray_en = 0;
    repeat (5) @(posedge clk);
    chk("i_q_drained", i_q.size(), 0);
    chk("d_q_drained", d_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
